lzrw_stream_decompressor: RTL and testbench
===========================================

LZRW_STREAM_DECOMPRESSOR -- requirements
Module: lzrw_stream_decompressor

Interface
REQ-001 SHALL have parameter HISTORY_SIZE, default 4096, history depth in bytes; power of two, 16..4096.
REQ-002 SHALL have parameter OFFSET_WIDTH, default 12, width of the copy-item offset field; HISTORY_SIZE <= 2**OFFSET_WIDTH.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous stream restart; empties history, clears err.
REQ-006 SHALL have port data_in  input  16  item: literal in [7:0]; copy item as offset [15:4], length code [3:0].
REQ-007 SHALL have port control_bit_in  input  1  0 = literal item, 1 = copy item.
REQ-008 SHALL have port in_valid  input  1  item offered.
REQ-009 SHALL have port in_ready  output  1  item accepted when in_valid & in_ready.
REQ-010 SHALL have port out_byte  output  8  decompressed byte.
REQ-011 SHALL have port out_valid  output  1  out_byte valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts byte when out_valid & out_ready.
REQ-013 SHALL have port err  output  1  sticky illegal-offset flag.
REQ-014 SHALL have port byte_count  output  16  bytes emitted since reset or clear; saturates at 16'hFFFF.

Function
REQ-015 SHALL implement FSM states IDLE, LIT, COPY_RD, COPY_OUT.
REQ-016 SHALL drive in_ready = 1 only in IDLE with clear = 0.
REQ-017 SHALL, on a literal accepted at cycle t, enter LIT and assert out_valid with out_byte = data_in[7:0] at cycle t+1.
REQ-018 SHALL, on a copy accepted, set offset = data_in[15:4], remaining = data_in[3:0] + 3 (3..18), then go to COPY_RD.
REQ-019 SHALL in COPY_RD issue a synchronous history read at (wr_ptr - offset) mod HISTORY_SIZE, then go to COPY_OUT next cycle.
REQ-020 SHALL in COPY_OUT hold out_valid = 1 with the read byte and keep it stable until out_ready = 1.
REQ-021 SHALL, on each output handshake, write out_byte to history at wr_ptr, increment wr_ptr mod HISTORY_SIZE, and increment byte_count.
REQ-022 SHALL after a COPY_OUT handshake decrement remaining; go to COPY_RD if nonzero, else IDLE. Copy throughput is therefore one byte per two cycles.
REQ-023 SHALL support overlapping copies (offset < length) correctly, since each byte is written before the next read.
REQ-024 SHALL after a LIT handshake return to IDLE; out_valid deasserts in the next cycle unless a new item is already accepted.
REQ-025 SHALL treat a copy as illegal if offset = 0, offset >= HISTORY_SIZE, or offset > bytes held (fill count, saturating at HISTORY_SIZE).
REQ-026 SHALL on an illegal copy set err = 1, consume the item, emit no bytes, and remain in IDLE.
REQ-027 SHALL make clear take priority over all activity: FSM to IDLE, out_valid = 0, wr_ptr = 0, fill count = 0, byte_count = 0, err = 0 next cycle.
REQ-028 SHALL leave history RAM contents undefined after clear or reset; the fill count alone governs legality.

Reset
REQ-029 SHALL on reset = 0 asynchronously force state IDLE, in_ready = 0, out_valid = 0, out_byte = 0, err = 0, byte_count = 0, wr_ptr = 0, fill count = 0.
REQ-030 SHALL, on reset mid-copy, abandon the remaining bytes; in_ready rises in the first cycle after reset deasserts.

Structure
REQ-031 SHALL take from shared package lzrw_pkg: state enum, MIN_MATCH = 3, LEN_CODE_WIDTH = 4, ITEM_WIDTH = 16.
REQ-032 SHALL instantiate one sub-module lzrw_history_ram: single-port-write / single-port-read, depth HISTORY_SIZE x 8, 1-cycle synchronous read.

Verification
REQ-033 SHALL verify literal: literal 0x0041 accepted at cycle t -> out_byte = 0x41, out_valid = 1 at t+1, byte_count = 1.
REQ-034 SHALL verify overlapping copy: literals 'a','b', then copy offset 2, code 1 -> output "ababab", byte_count = 6.
REQ-035 SHALL verify backpressure: out_ready = 0 for 5 cycles mid-copy -> out_byte and out_valid stable, in_ready = 0, no byte lost.
REQ-036 SHALL verify illegal offset: first item is a copy with offset 5 -> err = 1, no out_valid, in_ready = 1 next cycle; clear -> err = 0.
REQ-037 SHALL verify wrap: HISTORY_SIZE = 16, 20 literals 0x00..0x13, then copy offset 15, code 0 -> output 0x05, 0x06, 0x07.
REQ-038 SHALL verify reset mid-copy: reset asserted during COPY_OUT -> out_valid = 0, byte_count = 0 immediately; a subsequent literal decodes normally.

Source files
------------

// File: rtl/lzrw_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lzrw_pkg : shared item-format constants and decoder state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
package lzrw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LIT      = 2'd1,
        COPY_RD  = 2'd2,
        COPY_OUT = 2'd3
    } state_t;

    localparam int MIN_MATCH      = 3;
    localparam int LEN_CODE_WIDTH = 4;
    localparam int ITEM_WIDTH     = 16;

endpackage
`default_nettype wire

// File: rtl/lzrw_history_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lzrw_history_ram : byte history, one write port, one 1-cycle registered read port
// Revision : 1.0
// ---------------------------------------------------------------------------
module lzrw_history_ram #(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/lzrw_stream_decompressor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lzrw_stream_decompressor : literal/copy item stream to byte stream decoder
// Revision : 1.0
// ---------------------------------------------------------------------------
module lzrw_stream_decompressor
    import lzrw_pkg::*;
#(
    parameter int HISTORY_SIZE = 4096,
    parameter int OFFSET_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [ITEM_WIDTH-1:0] data_in,
    input  logic                  control_bit_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    output logic [15:0]           byte_count
);

    localparam int ADDR_WIDTH = $clog2(HISTORY_SIZE);
    localparam int REM_WIDTH  = LEN_CODE_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   FILL_MAX = (ADDR_WIDTH+1)'(HISTORY_SIZE);
    localparam logic [OFFSET_WIDTH:0] HIST_EXT = (OFFSET_WIDTH+1)'(HISTORY_SIZE);

    state_t                state;
    logic                  ready_q;
    logic [7:0]            lit_byte;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   fill_count;
    logic [ADDR_WIDTH-1:0] offset_q;
    logic [REM_WIDTH-1:0]  remaining;
    logic [7:0]            ram_byte;

    logic [OFFSET_WIDTH-1:0] item_offset;
    logic [OFFSET_WIDTH:0]   offset_ext;
    logic [OFFSET_WIDTH:0]   fill_ext;
    logic                    illegal;
    logic                    in_fire;
    logic                    out_fire;

    assign in_ready    = ready_q & ~clear;
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign out_byte    = (state == COPY_OUT) ? ram_byte : lit_byte;

    assign item_offset = data_in[LEN_CODE_WIDTH +: OFFSET_WIDTH];
    assign offset_ext  = {1'b0, item_offset};
    assign fill_ext    = (OFFSET_WIDTH+1)'(fill_count);
    // Legality is judged only against bytes actually written since restart.
    assign illegal     = (item_offset == '0) || (offset_ext >= HIST_EXT) ||
                         (offset_ext > fill_ext);

    lzrw_history_ram #(
        .DEPTH      (HISTORY_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_history (
        .clock   (clock),
        .wr_en   (out_fire & ~clear),
        .wr_addr (wr_ptr),
        .wr_data (out_byte),
        .rd_en   ((state == COPY_RD) & ~clear),
        .rd_addr (wr_ptr - offset_q),
        .rd_data (ram_byte)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            out_valid  <= 1'b0;
            lit_byte   <= 8'h00;
            err        <= 1'b0;
            byte_count <= 16'h0000;
            wr_ptr     <= '0;
            fill_count <= '0;
            offset_q   <= '0;
            remaining  <= '0;
        end else if (clear) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            byte_count <= 16'h0000;
            wr_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (out_fire) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (fill_count != FILL_MAX) begin
                    fill_count <= fill_count + (ADDR_WIDTH+1)'(1);
                end
                if (byte_count != 16'hFFFF) begin
                    byte_count <= byte_count + 16'd1;
                end
            end
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (in_fire) begin
                        if (!control_bit_in) begin
                            state     <= LIT;
                            ready_q   <= 1'b0;
                            out_valid <= 1'b1;
                            lit_byte  <= data_in[7:0];
                        end else if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            state     <= COPY_RD;
                            ready_q   <= 1'b0;
                            offset_q  <= item_offset[ADDR_WIDTH-1:0];
                            remaining <= REM_WIDTH'(data_in[LEN_CODE_WIDTH-1:0]) +
                                         REM_WIDTH'(MIN_MATCH);
                        end
                    end
                end
                LIT: begin
                    if (out_fire) begin
                        state     <= IDLE;
                        ready_q   <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                COPY_RD: begin
                    state     <= COPY_OUT;
                    out_valid <= 1'b1;
                end
                COPY_OUT: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        if (remaining == REM_WIDTH'(1)) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            remaining <= remaining - REM_WIDTH'(1);
                            state     <= COPY_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lzrw_stream_decompressor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lzrw_stream_decompressor : directed + random items against a byte-queue model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_lzrw_stream_decompressor;

    localparam int H = 16;

    logic        clock;
    logic        reset;
    logic        clear;
    logic [15:0] data_in;
    logic        control_bit_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [15:0] byte_count;

    lzrw_stream_decompressor #(
        .HISTORY_SIZE (H),
        .OFFSET_WIDTH (12)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .data_in        (data_in),
        .control_bit_in (control_bit_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .err            (err),
        .byte_count     (byte_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: every byte ever emitted since restart, plus pending output.
    logic [7:0] hist[$];
    logic [7:0] expq[$];
    logic       exp_err = 1'b0;
    logic [7:0] got_log[$];

    task automatic model_flush();
        hist.delete();
        expq.delete();
        exp_err = 1'b0;
    endtask

    task automatic model_item(input bit ctrl, input logic [15:0] d);
        int off, len, held;
        if (!ctrl) begin
            hist.push_back(d[7:0]);
            expq.push_back(d[7:0]);
        end else begin
            off  = int'(d[15:4]);
            len  = int'(d[3:0]) + 3;
            held = (hist.size() > H) ? H : hist.size();
            if (off == 0 || off >= H || off > held) begin
                exp_err = 1'b1;
            end else begin
                for (int i = 0; i < len; i++) begin
                    logic [7:0] b;
                    b = hist[hist.size() - off];
                    hist.push_back(b);
                    expq.push_back(b);
                end
            end
        end
    endtask

    // Consumer: 0 = always ready, 1 = random, 2 = hold off.
    int         ready_mode = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset || clear) begin
                prev_stall = 1'b0;
                out_ready  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_value("hold_valid", {31'd0, out_valid}, 32'd1);
                    check_value("hold_byte", {24'd0, out_byte}, {24'd0, prev_byte});
                end
                case (ready_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(0, 2) != 0);
                    default: out_ready = 1'b0;
                endcase
                if (out_valid) begin
                    check_value("busy_in_ready", {31'd0, in_ready}, 32'd0);
                    if (out_ready) begin
                        if (expq.size() == 0) check_value("extra_byte", 32'(expq.size()), 32'd1);
                        else check_value("out_byte", {24'd0, out_byte}, {24'd0, expq.pop_front()});
                        got_log.push_back(out_byte);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_byte  = out_byte;
            end
        end
    end

    task automatic send(input bit ctrl, input logic [15:0] d);
        int n = 0;
        @(negedge clock); #1;
        while (!in_ready && n < 500) begin
            @(negedge clock); #1;
            n++;
        end
        check_value("send_wait", {31'd0, n < 500}, 32'd1);
        in_valid       = 1'b1;
        data_in        = d;
        control_bit_in = ctrl;
        model_item(ctrl, d);
        @(negedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clock); #1;
            n++;
        end while (!(expq.size() == 0 && in_ready && !out_valid) && n < 3000);
        check_value("drain_wait", {31'd0, n < 3000}, 32'd1);
    endtask

    task automatic do_clear();
        @(negedge clock); #1;
        clear = 1'b1;
        model_flush();
        @(negedge clock); #1;
        clear = 1'b0;
        got_log.delete();
    endtask

    task automatic wait_out_valid();
        int n = 0;
        @(negedge clock); #1;
        while (!out_valid && n < 100) begin
            @(negedge clock); #1;
            n++;
        end
        check_value("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    logic [7:0] abab [6] = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62};

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        data_in = 16'h0000; control_bit_in = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check_value("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_out_byte", {24'd0, out_byte}, 32'd0);
        check_value("rst_err", {31'd0, err}, 32'd0);
        check_value("rst_count", {16'd0, byte_count}, 32'd0);
        reset = 1'b1;
        @(negedge clock); #1;
        check_value("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single literal: visible the cycle after acceptance
        send(1'b0, 16'h0041);
        check_value("lit_valid", {31'd0, out_valid}, 32'd1);
        check_value("lit_byte", {24'd0, out_byte}, 32'h41);
        drain();
        check_value("lit_count", {16'd0, byte_count}, 32'd1);

        // Overlapping copy
        do_clear();
        send(1'b0, 16'h0061);
        send(1'b0, 16'h0062);
        send(1'b1, 16'h0021);
        drain();
        check_value("abab_len", 32'(got_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_log.size(); i++)
            check_value("abab_byte", {24'd0, got_log[i]}, {24'd0, abab[i]});
        check_value("abab_count", {16'd0, byte_count}, 32'd6);

        // Backpressure during a long copy
        do_clear();
        send(1'b0, 16'h0011);
        send(1'b0, 16'h0022);
        send(1'b1, 16'h002F);
        wait_out_valid();
        ready_mode = 2;
        repeat (8) begin
            @(negedge clock); #1;
            check_value("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        ready_mode = 1;
        drain();
        check_value("bp_count", {16'd0, byte_count}, 32'd20);
        ready_mode = 0;

        // Illegal offset on an empty history, then clear
        do_clear();
        send(1'b1, 16'h0050);
        check_value("ill_err", {31'd0, err}, 32'd1);
        check_value("ill_valid", {31'd0, out_valid}, 32'd0);
        check_value("ill_in_ready", {31'd0, in_ready}, 32'd1);
        do_clear();
        @(negedge clock); #1;
        check_value("clr_err", {31'd0, err}, 32'd0);
        check_value("clr_count", {16'd0, byte_count}, 32'd0);

        // History wrap
        do_clear();
        for (int i = 0; i < 20; i++) send(1'b0, 16'(i));
        send(1'b1, 16'h00F0);
        drain();
        check_value("wrap_len", 32'(got_log.size()), 32'd23);
        if (got_log.size() == 23) begin
            check_value("wrap_b0", {24'd0, got_log[20]}, 32'h05);
            check_value("wrap_b1", {24'd0, got_log[21]}, 32'h06);
            check_value("wrap_b2", {24'd0, got_log[22]}, 32'h07);
        end

        // Reset in the middle of a copy
        ready_mode = 1;
        send(1'b1, 16'h003F);
        wait_out_valid();
        #2 reset = 1'b0;
        #1;
        check_value("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_value("mid_rst_count", {16'd0, byte_count}, 32'd0);
        model_flush();
        @(negedge clock); #1;
        reset = 1'b1;
        got_log.delete();
        @(negedge clock); #1;
        check_value("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(1'b0, 16'h005A);
        drain();
        check_value("mid_rst_count1", {16'd0, byte_count}, 32'd1);
        check_value("mid_rst_lit", {24'd0, (got_log.size() > 0) ? got_log[got_log.size()-1] : 8'h00}, 32'h5A);

        // Random item streams with random consumer stalls
        for (int round = 0; round < 4; round++) begin
            do_clear();
            for (int k = 0; k < 40; k++) begin
                int held, r, off;
                held = (hist.size() > H) ? H : hist.size();
                r = int'($urandom_range(0, 9));
                if (r < 4) begin
                    send(1'b0, 16'($urandom_range(0, 255)));
                end else begin
                    if (r == 4)      off = 0;
                    else if (r == 5) off = held + 1 + int'($urandom_range(0, 40));
                    else if (r == 6) off = int'($urandom_range(0, 4095));
                    else             off = 1 + int'($urandom_range(0, (held > 1) ? held - 1 : 0));
                    send(1'b1, {12'(off), 4'($urandom_range(0, 15))});
                end
            end
            drain();
            check_value("rnd_err", {31'd0, err}, {31'd0, exp_err});
            check_value("rnd_count", {16'd0, byte_count}, 32'(hist.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
